// File: rtl/rgb_led_pkg.sv
// rtl/rgb_led_pkg.sv - shared types and constants for the RGB LED PWM controller
package rgb_led_pkg;

  localparam int NUM_LEDS   = 4;
  localparam int NUM_COLORS = 3;
  localparam int PWM_W      = 8;

  typedef logic [PWM_W-1:0] duty_t;

  typedef enum logic [1:0] {
    COL_R   = 2'd0,
    COL_G   = 2'd1,
    COL_B   = 2'd2,
    COL_ALL = 2'd3
  } color_e;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_e;

  // True when a write with colour selector sel must update colour slot col.
  function automatic logic color_hit(input logic [1:0] sel, input logic [1:0] col);
    return (sel == COL_ALL) || (sel == col);
  endfunction

endpackage

// File: rtl/rgb_pwm_timebase.sv
// rtl/rgb_pwm_timebase.sv - prescaler and PWM step counter with frame boundary strobe
module rgb_pwm_timebase #(
  parameter int PRESCALE = 390,
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                fb
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  logic             step;

  assign step = (pre_cnt == PRE_MAX);
  assign fb   = step && (pwm_cnt == '1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      if (step) begin
        pre_cnt <= '0;
        pwm_cnt <= pwm_cnt + 1'b1;
      end else begin
        pre_cnt <= pre_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_led_pwm_ctrl.sv
// rtl/rgb_led_pwm_ctrl.sv - 12-channel PWM LED driver with shadow table and frame-aligned commit
module rgb_led_pwm_ctrl
  import rgb_led_pkg::*;
#(
  parameter int PRESCALE = 390,
  parameter int PWM_BITS = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [1:0] cfg_led,
  input  logic [1:0] cfg_color,
  input  logic [7:0] cfg_duty,
  input  logic       cfg_commit,
  output logic       commit_pending,
  output logic       frame_tick,
  output logic [3:0] led_r,
  output logic [3:0] led_g,
  output logic [3:0] led_b
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic                fb;
  state_e              state;

  duty_t shadow [NUM_LEDS][NUM_COLORS];
  duty_t active [NUM_LEDS][NUM_COLORS];

  rgb_pwm_timebase #(
    .PRESCALE(PRESCALE),
    .PWM_BITS(PWM_BITS)
  ) u_timebase (
    .CLK    (CLK),
    .RST    (RST),
    .pwm_cnt(pwm_cnt),
    .fb     (fb)
  );

  // cfg_ready is low throughout PENDING, which is what freezes the shadow table.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NUM_LEDS; i++)
        for (int c = 0; c < NUM_COLORS; c++)
          shadow[i][c] <= '0;
    end else if (cfg_valid && cfg_ready) begin
      for (int c = 0; c < NUM_COLORS; c++)
        if (color_hit(cfg_color, 2'(c)))
          shadow[cfg_led][c] <= cfg_duty;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= S_IDLE;
      cfg_ready      <= 1'b1;
      commit_pending <= 1'b0;
      for (int i = 0; i < NUM_LEDS; i++)
        for (int c = 0; c < NUM_COLORS; c++)
          active[i][c] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_commit) begin
            state          <= S_PENDING;
            cfg_ready      <= 1'b0;
            commit_pending <= 1'b1;
          end
        end
        S_PENDING: begin
          if (fb) begin
            for (int i = 0; i < NUM_LEDS; i++)
              for (int c = 0; c < NUM_COLORS; c++)
                active[i][c] <= shadow[i][c];
            state          <= S_IDLE;
            cfg_ready      <= 1'b1;
            commit_pending <= 1'b0;
          end
        end
        default: begin
          state          <= S_IDLE;
          cfg_ready      <= 1'b1;
          commit_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      frame_tick <= 1'b0;
      led_r      <= '0;
      led_g      <= '0;
      led_b      <= '0;
    end else begin
      frame_tick <= fb;
      for (int i = 0; i < NUM_LEDS; i++) begin
        led_r[i] <= (active[i][COL_R] > pwm_cnt);
        led_g[i] <= (active[i][COL_G] > pwm_cnt);
        led_b[i] <= (active[i][COL_B] > pwm_cnt);
      end
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// tb/tb_rgb_led_pwm_ctrl.sv - self-checking bench with cycle-count reference model
module tb_rgb_led_pwm_ctrl;

  localparam int P     = 2;
  localparam int FRAME = 256 * P;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_led = 2'd0;
  logic [1:0] cfg_color = 2'd0;
  logic [7:0] cfg_duty = 8'd0;
  logic       cfg_commit = 1'b0;
  logic       commit_pending;
  logic       frame_tick;
  logic [3:0] led_r, led_g, led_b;

  always #5 CLK = ~CLK;

  rgb_led_pwm_ctrl #(.PRESCALE(P), .PWM_BITS(8)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_led       (cfg_led),
    .cfg_color     (cfg_color),
    .cfg_duty      (cfg_duty),
    .cfg_commit    (cfg_commit),
    .commit_pending(commit_pending),
    .frame_tick    (frame_tick),
    .led_r         (led_r),
    .led_g         (led_g),
    .led_b         (led_b)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: timing derived from the number of clock edges since reset.
  int         m_sh [4][3];
  int         m_ac [4][3];
  bit         m_pend;
  int         m_n;
  logic [3:0] e_r, e_g, e_b;
  bit         e_tick;
  bit         model_on = 1'b0;

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      for (int i = 0; i < 4; i++)
        for (int c = 0; c < 3; c++) begin
          m_sh[i][c] = 0;
          m_ac[i][c] = 0;
        end
      m_pend = 1'b0; m_n = 0;
      e_r = '0; e_g = '0; e_b = '0; e_tick = 1'b0;
      model_on = 1'b1;
    end else begin
      int pwm;
      bit fbm;
      pwm = (m_n / P) % 256;
      fbm = (m_n % FRAME) == FRAME - 1;
      for (int i = 0; i < 4; i++) begin
        e_r[i] = m_ac[i][0] > pwm;
        e_g[i] = m_ac[i][1] > pwm;
        e_b[i] = m_ac[i][2] > pwm;
      end
      e_tick = fbm;
      if (cfg_valid && !m_pend)
        for (int c = 0; c < 3; c++)
          if (cfg_color == 2'd3 || int'(cfg_color) == c) m_sh[cfg_led][c] = cfg_duty;
      if (!m_pend && cfg_commit) m_pend = 1'b1;
      else if (m_pend && fbm) begin
        m_ac = m_sh;
        m_pend = 1'b0;
      end
      m_n++;
    end
  end

  initial forever begin
    @(negedge CLK);
    if (model_on) begin
      check("led_r", led_r, e_r);
      check("led_g", led_g, e_g);
      check("led_b", led_b, e_b);
      check("frame_tick", frame_tick, e_tick);
      check("cfg_ready", cfg_ready, !m_pend);
      check("commit_pending", commit_pending, m_pend);
    end
  end

  int cnt_r [4], cnt_g [4], cnt_b [4];

  task automatic count_frame();
    for (int i = 0; i < 4; i++) begin cnt_r[i] = 0; cnt_g[i] = 0; cnt_b[i] = 0; end
    repeat (FRAME) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] += int'(led_r[i]); cnt_g[i] += int'(led_g[i]); cnt_b[i] += int'(led_b[i]);
      end
    end
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 2 * FRAME + 4; k++) begin
      @(negedge CLK);
      if (frame_tick) return;
    end
    check("wait_tick timeout", 0, 1);
  endtask

  task automatic commit_pulse();
    cfg_commit = 1'b1;
    @(negedge CLK);
    cfg_commit = 1'b0;
  endtask

  // Holds the request until accepted; reports wait length and frame_tick at acceptance.
  task automatic do_write(input int l, input int c, input int d, input bit cm,
                          output int waited, output bit tick_at_acc);
    cfg_valid = 1'b1; cfg_led = 2'(l); cfg_color = 2'(c); cfg_duty = 8'(d); cfg_commit = cm;
    waited = 0;
    while (!cfg_ready && waited < 3 * FRAME) begin
      @(negedge CLK);
      cfg_commit = 1'b0;
      waited++;
    end
    if (!cfg_ready) check("write accept timeout", 0, 1);
    tick_at_acc = frame_tick;
    @(negedge CLK);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
  endtask

  initial begin
    int  w;
    bit  tk;
    longint t1, t2;
    int  others;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check("reset led_r", led_r, 0);
    check("reset cfg_ready", cfg_ready, 1);
    check("reset commit_pending", commit_pending, 0);

    // Idle frames: period of frame_tick and dark outputs
    wait_tick(); t1 = $time;
    wait_tick(); t2 = $time;
    check("tick period", int'((t2 - t1) / 10), FRAME);
    count_frame();
    others = 0;
    for (int i = 0; i < 4; i++) others += cnt_r[i] + cnt_g[i] + cnt_b[i];
    check("idle dark", others, 0);

    // LED1 red at 50%
    do_write(1, 0, 128, 1'b0, w, tk);
    commit_pulse();
    check("pending after commit", commit_pending, 1);
    wait_tick();
    count_frame();
    check("led_r1 duty128", cnt_r[1], 256);
    others = 0;
    for (int i = 0; i < 4; i++) others += cnt_g[i] + cnt_b[i] + ((i != 1) ? cnt_r[i] : 0);
    check("others dark", others, 0);

    // LED2 all colours 255, no commit yet
    do_write(2, 3, 255, 1'b0, w, tk);
    count_frame();
    check("uncommitted led2", cnt_r[2] + cnt_g[2] + cnt_b[2], 0);
    commit_pulse();
    wait_tick();
    count_frame();
    check("led_r2 duty255", cnt_r[2], 510);
    check("led_g2 duty255", cnt_g[2], 510);
    check("led_b2 duty255", cnt_b[2], 510);
    check("led_r1 kept", cnt_r[1], 256);

    // Write held off during PENDING
    commit_pulse();
    check("ready low pending", cfg_ready, 0);
    do_write(0, 1, 64, 1'b0, w, tk);
    check("write stalled", int'(w > 0), 1);
    check("accept after fb", tk, 1);
    count_frame();
    check("led_g0 not committed", cnt_g[0], 0);
    commit_pulse();
    wait_tick();
    count_frame();
    check("led_g0 duty64", cnt_g[0], 128);

    // Same-cycle write and commit
    do_write(3, 2, 10, 1'b1, w, tk);
    wait_tick();
    count_frame();
    check("led_b3 duty10", cnt_b[3], 20);

    // Randomized traffic against the model
    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 300)) @(negedge CLK);
      case ($urandom_range(0, 3))
        0: commit_pulse();
        default: do_write($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 255), 1'($urandom_range(0, 3) == 0), w, tk);
      endcase
    end
    if (!commit_pending) commit_pulse();
    wait_tick();
    do_write(0, 0, 200, 1'b0, w, tk);
    commit_pulse();

    // Reset while PENDING with live duties
    repeat (100) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("rst led_r", led_r, 0);
    check("rst led_g", led_g, 0);
    check("rst led_b", led_b, 0);
    check("rst commit_pending", commit_pending, 0);
    check("rst cfg_ready", cfg_ready, 1);
    @(negedge CLK);
    RST = 1'b0;
    count_frame();
    count_frame();
    others = 0;
    for (int i = 0; i < 4; i++) others += cnt_r[i] + cnt_g[i] + cnt_b[i];
    check("no commit after reset", others, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #(900000);
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
